line_ring_writer: RTL and testbench

LINE_RING_WRITER -- requirements
Module: line_ring_writer

---
 rtl/line_ring_writer_if.sv | 26 ++
 rtl/line_ring_writer.sv | 156 +++++++++++++++
 tb/tb_line_ring_writer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/line_ring_writer_if.sv
// Video-in / RAM-write bundle for line_ring_writer.
// master = the writer (consumes raster, drives RAM port); slave = its environment.
interface line_ring_writer_if #(
  parameter int PIXEL_W = 24,
  parameter int ADDR_W  = 15
);
  logic               line_doubler;
  logic [11:0]        counterX;
  logic [11:0]        counterY;
  logic [PIXEL_W-1:0] pixel;
  logic               wren;
  logic [ADDR_W-1:0]  wraddr;
  logic [PIXEL_W-1:0] wrdata;
  logic               starttrigger;
  logic               frame_done;

  modport master (
    input  line_doubler, counterX, counterY, pixel,
    output wren, wraddr, wrdata, starttrigger, frame_done
  );

  modport slave (
    output line_doubler, counterX, counterY, pixel,
    input  wren, wraddr, wrdata, starttrigger, frame_done
  );
endinterface

// File: rtl/line_ring_writer.sv
// Captures the active window of an incoming raster into a ring of line slots
// in a buffer RAM. Signals the reader once TRIGGER_LINES lines are banked and
// flags the end of each frame.
//
// state | meaning
// IDLE  | waiting for the first pixel of a frame (counterX==H_START, counterY==V_START)
// FILL  | writing lines, reader not yet released
// RUN   | writing lines, reader released (starttrigger already pulsed)
module line_ring_writer #(
  parameter int PIXEL_W       = 24,
  parameter int ADDR_W        = 15,
  parameter int H_ACTIVE      = 640,
  parameter int H_START       = 0,
  parameter int V_START       = 0,
  parameter int V_ACTIVE      = 480,
  parameter int RING_LINES    = 48,
  parameter int TRIGGER_LINES = 2
) (
  input  logic clock,
  input  logic reset,
  line_ring_writer_if.master bus
);

  localparam longint RING_SPAN = longint'(RING_LINES) * longint'(H_ACTIVE);
  localparam int     LAST_BASE = (RING_LINES - 1) * H_ACTIVE;

  generate
    if (RING_SPAN > (longint'(1) << ADDR_W)) begin : g_ring_too_big
      $error("line_ring_writer: RING_LINES*H_ACTIVE exceeds the write address space");
    end
    if (TRIGGER_LINES > RING_LINES) begin : g_trigger_too_big
      $error("line_ring_writer: TRIGGER_LINES exceeds RING_LINES");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [ADDR_W-1:0]  line_base_q, line_base_d;
  logic [11:0]        line_cnt_q, line_cnt_d;
  logic               wren_q, wren_d;
  logic [ADDR_W-1:0]  wraddr_q, wraddr_d;
  logic [PIXEL_W-1:0] wrdata_q, wrdata_d;
  logic               start_q, start_d;
  logic               done_q, done_d;

  // Next-state, write-port and line bookkeeping for the current raster sample.
  always_comb begin
    int          x_i;
    int          y_i;
    int          v_lines;
    logic        mode_now;
    logic        in_win;
    logic        line_end;
    logic        do_write;
    logic [11:0] cnt_inc;

    state_d     = state_q;
    mode_d      = mode_q;
    line_base_d = line_base_q;
    line_cnt_d  = line_cnt_q;
    wren_d      = 1'b0;
    wraddr_d    = wraddr_q;
    wrdata_d    = wrdata_q;
    start_d     = 1'b0;
    done_d      = 1'b0;
    do_write    = 1'b0;
    cnt_inc     = '0;

    x_i = int'(bus.counterX);
    y_i = int'(bus.counterY);
    // The start cycle already needs the new frame's mode before it is latched.
    mode_now = (state_q == IDLE) ? bus.line_doubler : mode_q;
    v_lines  = mode_now ? (V_ACTIVE / 2) : V_ACTIVE;
    in_win   = (x_i >= H_START) && (x_i < H_START + H_ACTIVE) &&
               (y_i >= V_START) && (y_i < V_START + v_lines);
    line_end = (x_i == H_START + H_ACTIVE - 1);

    case (state_q)
      IDLE: begin
        if (x_i == H_START && y_i == V_START) begin
          state_d  = FILL;
          mode_d   = bus.line_doubler;
          do_write = in_win;
        end
      end
      default: begin
        // Raster jumped back above the window: source resynced, drop the frame.
        if (y_i < V_START) begin
          state_d     = IDLE;
          line_base_d = '0;
          line_cnt_d  = '0;
        end else begin
          do_write = in_win;
        end
      end
    endcase

    if (do_write) begin
      wren_d   = 1'b1;
      wrdata_d = bus.pixel;
      wraddr_d = line_base_q + ADDR_W'(x_i - H_START);
      if (line_end) begin
        cnt_inc     = line_cnt_q + 12'd1;
        line_cnt_d  = cnt_inc;
        line_base_d = (int'(line_base_q) == LAST_BASE) ? '0
                                                       : line_base_q + ADDR_W'(H_ACTIVE);
        // Short frames never reach TRIGGER_LINES; release the reader at frame end.
        if (int'(cnt_inc) == TRIGGER_LINES ||
            (int'(cnt_inc) == v_lines && v_lines <= TRIGGER_LINES)) begin
          start_d = 1'b1;
          state_d = RUN;
        end
        if (int'(cnt_inc) == v_lines) begin
          done_d      = 1'b1;
          line_base_d = '0;
          line_cnt_d  = '0;
          state_d     = IDLE;
        end
      end
    end
  end

  // State and registered RAM write port; synchronous reset wins over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      line_base_q <= '0;
      line_cnt_q  <= '0;
      wren_q      <= 1'b0;
      wraddr_q    <= '0;
      wrdata_q    <= '0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      line_base_q <= line_base_d;
      line_cnt_q  <= line_cnt_d;
      wren_q      <= wren_d;
      wraddr_q    <= wraddr_d;
      wrdata_q    <= wrdata_d;
      start_q     <= start_d;
      done_q      <= done_d;
    end
  end

  assign bus.wren         = wren_q;
  assign bus.wraddr       = wraddr_q;
  assign bus.wrdata       = wrdata_q;
  assign bus.starttrigger = start_q;
  assign bus.frame_done   = done_q;

endmodule

// File: tb/tb_line_ring_writer.sv
// Directed bench: small raster (12 x 8 total, 8 x 6 active starting at X=2, Y=1),
// four-slot ring. dut2 differs only in TRIGGER_LINES=4 to cover late/short triggers.
module tb_line_ring_writer;
  localparam int PW = 24;
  localparam int AW = 5;
  localparam int HA = 8;
  localparam int HS = 2;
  localparam int VS = 1;
  localparam int VA = 6;
  localparam int RL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_ring_writer_if #(.PIXEL_W(PW), .ADDR_W(AW)) bus1 ();
  line_ring_writer_if #(.PIXEL_W(PW), .ADDR_W(AW)) bus2 ();

  line_ring_writer #(.PIXEL_W(PW), .ADDR_W(AW), .H_ACTIVE(HA), .H_START(HS),
                     .V_START(VS), .V_ACTIVE(VA), .RING_LINES(RL), .TRIGGER_LINES(2))
    dut1 (.clock(clk), .reset(rst), .bus(bus1));

  line_ring_writer #(.PIXEL_W(PW), .ADDR_W(AW), .H_ACTIVE(HA), .H_START(HS),
                     .V_START(VS), .V_ACTIVE(VA), .RING_LINES(RL), .TRIGGER_LINES(4))
    dut2 (.clock(clk), .reset(rst), .bus(bus2));

  int checks = 0;
  int passes = 0;

  int nwr, nstart, ndone, start_pos, done_pos, maxaddr, data_bad, oow_wr;
  int nstart2, ndone2, start2_pos, done2_pos, both2;
  int base_seen [8];

  function automatic logic [PW-1:0] pix(input int x, input int y);
    return {8'(y), 8'(x), 8'hA5};
  endfunction

  task automatic clear_stats();
    nwr = 0; nstart = 0; ndone = 0; start_pos = -1; done_pos = -1;
    maxaddr = -1; data_bad = 0; oow_wr = 0;
    nstart2 = 0; ndone2 = 0; start2_pos = -1; done2_pos = -1; both2 = 0;
    for (int i = 0; i < 8; i++) base_seen[i] = -1;
  endtask

  // Apply one raster sample, clock it, then tally what the registered outputs show.
  task automatic drive(input int x, input int y, input logic dbl, input logic r);
    bus1.counterX = 12'(x); bus1.counterY = 12'(y);
    bus1.line_doubler = dbl; bus1.pixel = pix(x, y);
    bus2.counterX = 12'(x); bus2.counterY = 12'(y);
    bus2.line_doubler = dbl; bus2.pixel = pix(x, y);
    rst = r;
    @(posedge clk);
    #1;
    if (bus1.wren === 1'b1) begin
      nwr++;
      if (bus1.wrdata !== pix(x, y)) data_bad++;
      if (int'(bus1.wraddr) > maxaddr) maxaddr = int'(bus1.wraddr);
      if (x == HS && y < 8) base_seen[y] = int'(bus1.wraddr);
      if (x < HS || x >= HS + HA) oow_wr++;
    end
    if (bus1.starttrigger === 1'b1) begin nstart++; start_pos = y * 100 + x; end
    if (bus1.frame_done === 1'b1) begin ndone++; done_pos = y * 100 + x; end
    if (bus2.starttrigger === 1'b1) begin nstart2++; start2_pos = y * 100 + x; end
    if (bus2.frame_done === 1'b1) begin ndone2++; done2_pos = y * 100 + x; end
    if (bus2.starttrigger === 1'b1 && bus2.frame_done === 1'b1) both2++;
  endtask

  // Full rows y0..7; from row toggle_y on (if >=0) line_doubler is inverted.
  task automatic scan_frame(input logic dbl, input int toggle_y, input int y0);
    for (int y = y0; y < 8; y++)
      for (int x = 0; x < 12; x++)
        drive(x, y, (toggle_y >= 0 && y >= toggle_y) ? ~dbl : dbl, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) drive(HS, VS, 1'b0, 1'b1);
    checks++; if (bus1.wren !== 1'b0) $display("FAIL rst_wren got=%b exp=0", bus1.wren); else passes++;
    checks++; if (bus1.wraddr !== '0) $display("FAIL rst_wraddr got=%0d exp=0", bus1.wraddr); else passes++;
    checks++; if (bus1.wrdata !== '0) $display("FAIL rst_wrdata got=%h exp=0", bus1.wrdata); else passes++;
    checks++; if (bus1.starttrigger !== 1'b0) $display("FAIL rst_start got=%b exp=0", bus1.starttrigger); else passes++;
    checks++; if (bus1.frame_done !== 1'b0) $display("FAIL rst_done got=%b exp=0", bus1.frame_done); else passes++;
    drive(0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_progressive();
    clear_stats();
    scan_frame(1'b0, -1, 0);
    checks++; if (nwr !== 48) $display("FAIL prog_writes got=%0d exp=48", nwr); else passes++;
    checks++; if (base_seen[1] !== 0) $display("FAIL prog_base1 got=%0d exp=0", base_seen[1]); else passes++;
    checks++; if (base_seen[2] !== 8) $display("FAIL prog_base2 got=%0d exp=8", base_seen[2]); else passes++;
    checks++; if (base_seen[4] !== 24) $display("FAIL prog_base4 got=%0d exp=24", base_seen[4]); else passes++;
    checks++; if (base_seen[5] !== 0) $display("FAIL prog_wrap_base5 got=%0d exp=0", base_seen[5]); else passes++;
    checks++; if (base_seen[6] !== 8) $display("FAIL prog_base6 got=%0d exp=8", base_seen[6]); else passes++;
    checks++; if (maxaddr !== 31) $display("FAIL prog_maxaddr got=%0d exp=31", maxaddr); else passes++;
    checks++; if (nstart !== 1 || start_pos !== 209) $display("FAIL prog_start n=%0d pos=%0d exp n=1 pos=209", nstart, start_pos); else passes++;
    checks++; if (ndone !== 1 || done_pos !== 609) $display("FAIL prog_done n=%0d pos=%0d exp n=1 pos=609", ndone, done_pos); else passes++;
    checks++; if (data_bad !== 0) $display("FAIL prog_data bad=%0d exp=0", data_bad); else passes++;
    checks++; if (oow_wr !== 0) $display("FAIL prog_out_of_window writes=%0d exp=0", oow_wr); else passes++;
    checks++; if (bus1.wraddr !== 5'd15) $display("FAIL prog_hold_addr got=%0d exp=15", bus1.wraddr); else passes++;
    checks++; if (bus1.wrdata !== pix(9, 6)) $display("FAIL prog_hold_data got=%h exp=%h", bus1.wrdata, pix(9, 6)); else passes++;
    checks++; if (nstart2 !== 1 || start2_pos !== 409) $display("FAIL prog_start_t4 n=%0d pos=%0d exp n=1 pos=409", nstart2, start2_pos); else passes++;
    checks++; if (ndone2 !== 1 || done2_pos !== 609) $display("FAIL prog_done_t4 n=%0d pos=%0d exp n=1 pos=609", ndone2, done2_pos); else passes++;
  endtask

  task automatic test_line_doubler();
    clear_stats();
    scan_frame(1'b1, 2, 0);
    checks++; if (nwr !== 24) $display("FAIL dbl_writes got=%0d exp=24", nwr); else passes++;
    checks++; if (base_seen[3] !== 16) $display("FAIL dbl_base3 got=%0d exp=16", base_seen[3]); else passes++;
    checks++; if (base_seen[4] !== -1) $display("FAIL dbl_line4_written base=%0d exp=-1", base_seen[4]); else passes++;
    checks++; if (nstart !== 1 || start_pos !== 209) $display("FAIL dbl_start n=%0d pos=%0d exp n=1 pos=209", nstart, start_pos); else passes++;
    checks++; if (ndone !== 1 || done_pos !== 309) $display("FAIL dbl_done n=%0d pos=%0d exp n=1 pos=309", ndone, done_pos); else passes++;
    checks++; if (both2 !== 1 || start2_pos !== 309 || ndone2 !== 1) $display("FAIL dbl_short_frame_t4 both=%0d pos=%0d done=%0d exp 1/309/1", both2, start2_pos, ndone2); else passes++;
  endtask

  task automatic test_resync();
    clear_stats();
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 12; x++) drive(x, y, 1'b0, 1'b0);
    for (int x = 0; x < 5; x++) drive(x, 3, 1'b0, 1'b0);
    checks++; if (nwr !== 19 || nstart !== 1) $display("FAIL resync_pre writes=%0d starts=%0d exp 19/1", nwr, nstart); else passes++;
    drive(5, 0, 1'b0, 1'b0);
    checks++; if (bus1.wren !== 1'b0) $display("FAIL resync_no_write got=%b exp=0", bus1.wren); else passes++;
    for (int x = 6; x < 12; x++) drive(x, 0, 1'b0, 1'b0);
    checks++; if (ndone !== 0 || nwr !== 19) $display("FAIL resync_abort done=%0d writes=%0d exp 0/19", ndone, nwr); else passes++;
    clear_stats();
    scan_frame(1'b0, -1, 1);
    checks++; if (base_seen[1] !== 0 || base_seen[2] !== 8) $display("FAIL resync_restart base1=%0d base2=%0d exp 0/8", base_seen[1], base_seen[2]); else passes++;
    checks++; if (nstart !== 1 || start_pos !== 209 || ndone !== 1) $display("FAIL resync_next_frame start=%0d pos=%0d done=%0d exp 1/209/1", nstart, start_pos, ndone); else passes++;
  endtask

  task automatic test_reset_midline();
    clear_stats();
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 12; x++) drive(x, y, 1'b0, 1'b0);
    for (int x = 0; x < 6; x++) drive(x, 2, 1'b0, 1'b0);
    drive(6, 2, 1'b0, 1'b1);
    checks++; if (bus1.wren !== 1'b0 || bus1.starttrigger !== 1'b0 || bus1.frame_done !== 1'b0)
      $display("FAIL midrst_ctrl wren=%b start=%b done=%b exp 0/0/0", bus1.wren, bus1.starttrigger, bus1.frame_done); else passes++;
    checks++; if (bus1.wraddr !== '0 || bus1.wrdata !== '0) $display("FAIL midrst_bus addr=%0d data=%h exp 0/0", bus1.wraddr, bus1.wrdata); else passes++;
    clear_stats();
    for (int x = 7; x < 12; x++) drive(x, 2, 1'b0, 1'b0);
    scan_frame(1'b0, -1, 3);
    checks++; if (nwr !== 0) $display("FAIL midrst_partial_writes got=%0d exp=0", nwr); else passes++;
    clear_stats();
    scan_frame(1'b0, -1, 0);
    checks++; if (nwr !== 48 || base_seen[1] !== 0 || ndone !== 1) $display("FAIL midrst_next_frame writes=%0d base1=%0d done=%0d exp 48/0/1", nwr, base_seen[1], ndone); else passes++;
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_progressive();
    test_line_doubler();
    test_resync();
    test_reset_midline();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
